debug_bus_ram: RTL and testbench
================================

Name: debug_bus_ram

Overview:
- Bus slave placed directly downstream of the UART debug bridge; consumes its wr_en/wr_rdy and rd_en/rd_rdy request-hold handshake.
- Provides a word-addressed on-chip RAM window with configurable access latency, so the debug path can be exercised without a full SoC.
- Out-of-window requests are never acknowledged, so the master's timeout path stays reachable.

Parameters:
- AWIDTH, 4, address width in bytes (bus address = AWIDTH*8 bits).
- DWIDTH, 4, data width in bytes (bus data = DWIDTH*8 bits).
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- BASE_ADDR, 0, first word address of the window.
- RD_LATENCY, 2, cycles from request accept to rd_rdy; legal range is 1..255.
- WR_LATENCY, 1, cycles from request accept to wr_rdy; legal range is 1..255.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- wr_en  input  1  write request, held high by the master until wr_rdy
- wr_rdy  output  1  write acknowledge, one-cycle pulse
- wr_addr  input  AWIDTH*8  write word address
- wr_data  input  DWIDTH*8  write data
- rd_en  input  1  read request, held high by the master until rd_rdy
- rd_rdy  output  1  read acknowledge, one-cycle pulse
- rd_addr  input  AWIDTH*8  read word address
- rd_data  output  DWIDTH*8  read data, registered and held until the next read completes

Behaviour:
- Reset values: wr_rdy=0, rd_rdy=0, rd_data=0, FSM=IDLE, latency counter=0.
- RAM contents are not reset; they are initialised to 0 for simulation only.
- Window check: in_range = (addr >= BASE_ADDR) && (addr - BASE_ADDR < 2**DEPTH_LOG2). Word index = (addr - BASE_ADDR)[DEPTH_LOG2-1:0]. The subtraction is done at full AWIDTH*8 width with no wrap into the window.
- FSM states: IDLE, WR_WAIT, RD_WAIT, DONE.
- IDLE, accepting a request:
  - wr_en=1 and in_range(wr_addr): latch address and data, load counter with WR_LATENCY-1, go to WR_WAIT.
  - Otherwise, rd_en=1 and in_range(rd_addr): latch address, load counter with RD_LATENCY-1, go to RD_WAIT.
  - Write has priority when both requests are valid in the same cycle. The read stays pending (master holds rd_en) and is accepted after the write completes.
  - Out-of-range requests are ignored in IDLE: no rdy, no state change.
- WR_WAIT / RD_WAIT:
  - Counter decrements each cycle.
  - When the counter is 0 and the matching en is still 1, assert rdy for exactly one cycle and go to DONE.
  - A write is committed to the RAM in the wr_rdy cycle.
  - rd_data is loaded from the RAM so that it is valid in the rd_rdy cycle itself and stays stable afterwards. This supports masters that capture in the rdy cycle and masters that capture one cycle later.
- Abort: if the matching en falls while in a WAIT state, return to IDLE with no rdy, no RAM write and no rd_data change.
- DONE: rdy=0. Stay until the en just served is 0, then go to IDLE. This prevents a double acknowledge of a held request.
- Latency: with a request held from cycle T (sampled in IDLE at edge T), rdy is high in the cycle after edge T+LATENCY. LATENCY=1 means rdy is high in the cycle immediately after acceptance.
- Address and data changes during WAIT are ignored; the latched values are used.
- Reset mid-operation returns the block to IDLE immediately with outputs 0. RAM is untouched, and any in-flight write is discarded.

Optional Feature:
- Macro: DEBUG_BUS_RAM_STATS_EN.
- With the macro defined:
  - Extra outputs wr_cnt[31:0] and rd_cnt[31:0] count completed transactions; both reset to 0 and wrap from 2**32-1 to 0.
  - Extra output oor_cnt[15:0] counts out-of-range requests, incremented on each rising edge of an out-of-range en seen in IDLE, saturating at 16'hFFFF.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package debug_bus_pkg:
  - FSM state enum (IDLE, WR_WAIT, RD_WAIT, DONE).
  - Latency counter width localparam of 8 bits.
- Sub-module debug_bus_ram_core: single-clock simple dual-port RAM (1 write, 1 synchronous read), DEPTH_LOG2 x DWIDTH*8, inferable as block RAM.
- The handshake FSM and window check stay in the top level.

Test Plan:
- Write 0x00000010=0xDEADBEEF, then read 0x10 with default latencies → wr_rdy pulses 1 cycle after accept; rd_rdy pulses 2 cycles after accept with rd_data=0xDEADBEEF; rd_data is still 0xDEADBEEF the next cycle.
- Read at address 2**DEPTH_LOG2 (0x400), held for 600 cycles → rd_rdy never asserts and rd_data is unchanged. Repeat at 0x3FF → rd_rdy asserts with correct data.
- rd_en and wr_en raised together, wr 0x5=0x1234 and rd 0x5 → wr_rdy first; rd_rdy later returns 0x00001234; exactly one pulse each.
- RD_LATENCY=8; drop rd_en after 3 cycles → no rd_rdy and rd_data unchanged. WR_LATENCY=8; drop wr_en early → the following read shows the old value.
- Hold wr_en high 5 cycles after wr_rdy → single wr_rdy pulse; FSM stays in DONE until wr_en=0.
- Assert rstn=0 during RD_WAIT → rd_rdy=0 and rd_data=0 immediately. After release, RAM data written before reset reads back intact.

Source files
------------

// File: rtl/debug_bus_pkg.sv
// debug_bus_pkg: shared FSM states and latency counter width for debug_bus_ram
package debug_bus_pkg;

    localparam int LAT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/debug_bus_ram_core.sv
// debug_bus_ram_core: simple dual-port RAM, one write port and one synchronous read port; contents are never reset
module debug_bus_ram_core #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    // Registered read every cycle, write when enabled
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/debug_bus_ram.sv
// debug_bus_ram: word-addressed RAM window behind the UART debug bridge; define DEBUG_BUS_RAM_STATS_EN for transaction counters
module debug_bus_ram
    import debug_bus_pkg::*;
#(
    parameter int AWIDTH     = 4,
    parameter int DWIDTH     = 4,
    parameter int DEPTH_LOG2 = 10,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    output logic                wr_rdy,
    input  logic [AWIDTH*8-1:0] wr_addr,
    input  logic [DWIDTH*8-1:0] wr_data,
    input  logic                rd_en,
    output logic                rd_rdy,
    input  logic [AWIDTH*8-1:0] rd_addr,
    output logic [DWIDTH*8-1:0] rd_data
`ifdef DEBUG_BUS_RAM_STATS_EN
    ,
    output logic [31:0]         wr_cnt,
    output logic [31:0]         rd_cnt,
    output logic [15:0]         oor_cnt
`endif
);

    localparam int AW = AWIDTH * 8;
    localparam int DW = DWIDTH * 8;
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
    localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WR_LATENCY - 1);
    localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(RD_LATENCY - 1);

    state_t                state, state_nx;
    logic [LAT_W-1:0]      cnt, cnt_nx;
    logic                  is_wr;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx, rd_sel;
    logic [DW-1:0]         wr_buf, ram_q;
    logic [AW-1:0]         wr_off, rd_off;
    logic                  wr_ok, rd_ok, acc_wr, acc_rd, fire_wr, fire_rd;

    // Window check at full bus width so addresses below BASE cannot wrap into the window
    always_comb begin
        wr_off = wr_addr - BASE;
        rd_off = rd_addr - BASE;
        wr_ok  = (wr_addr >= BASE) && ((wr_off >> DEPTH_LOG2) == '0);
        rd_ok  = (rd_addr >= BASE) && ((rd_off >> DEPTH_LOG2) == '0);
        rd_sel = (state == IDLE) ? rd_off[DEPTH_LOG2-1:0] : rd_idx;
    end

    // Accept in IDLE with write priority, count down in WAIT, abort on a dropped en, hold DONE until en releases
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        fire_wr  = 1'b0;
        fire_rd  = 1'b0;
        case (state)
            IDLE: begin
                acc_wr   = wr_en && wr_ok;
                acc_rd   = !acc_wr && rd_en && rd_ok;
                state_nx = acc_wr ? WR_WAIT : acc_rd ? RD_WAIT : IDLE;
                cnt_nx   = acc_wr ? WR_LAT : acc_rd ? RD_LAT : cnt;
            end
            WR_WAIT: begin
                fire_wr  = wr_en && (cnt == '0);
                state_nx = !wr_en ? IDLE : fire_wr ? DONE : WR_WAIT;
                cnt_nx   = (cnt == '0) ? cnt : cnt - LAT_W'(1);
            end
            RD_WAIT: begin
                fire_rd  = rd_en && (cnt == '0);
                state_nx = !rd_en ? IDLE : fire_rd ? DONE : RD_WAIT;
                cnt_nx   = (cnt == '0) ? cnt : cnt - LAT_W'(1);
            end
            DONE:    state_nx = (is_wr ? wr_en : rd_en) ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake state, latched request and registered acknowledges / read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            is_wr   <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_buf  <= '0;
            wr_rdy  <= 1'b0;
            rd_rdy  <= 1'b0;
            rd_data <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            wr_rdy <= fire_wr;
            rd_rdy <= fire_rd;
            if (acc_wr) begin
                is_wr  <= 1'b1;
                wr_idx <= wr_off[DEPTH_LOG2-1:0];
                wr_buf <= wr_data;
            end
            if (acc_rd) begin
                is_wr  <= 1'b0;
                rd_idx <= rd_off[DEPTH_LOG2-1:0];
            end
            if (fire_rd) rd_data <= ram_q;
        end
    end

    debug_bus_ram_core #(
        .AW(DEPTH_LOG2),
        .DW(DW)
    ) u_core (
        .clk  (clk),
        .we   (fire_wr),
        .waddr(wr_idx),
        .wdata(wr_buf),
        .raddr(rd_sel),
        .rdata(ram_q)
    );

`ifdef DEBUG_BUS_RAM_STATS_EN
    logic wr_en_q, rd_en_q, oor;

    assign oor = (state == IDLE) && ((wr_en && !wr_en_q && !wr_ok) || (rd_en && !rd_en_q && !rd_ok));

    // Completed-transaction counters wrap; out-of-range request counter saturates
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            oor_cnt <= '0;
        end else begin
            wr_en_q <= wr_en;
            rd_en_q <= rd_en;
            wr_cnt  <= wr_cnt + 32'(fire_wr);
            rd_cnt  <= rd_cnt + 32'(fire_rd);
            oor_cnt <= (oor && oor_cnt != '1) ? oor_cnt + 16'd1 : oor_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_debug_bus_ram.sv
// tb_debug_bus_ram: randomized and directed checks of two debug_bus_ram instances against a transaction-level model
module tb_debug_bus_ram;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en [N];
    logic        rd_en [N];
    logic        wr_rdy [N];
    logic        rd_rdy [N];
    logic [31:0] wr_addr [N];
    logic [31:0] wr_data [N];
    logic [31:0] rd_addr [N];
    logic [31:0] rd_data [N];

`ifdef DEBUG_BUS_RAM_STATS_EN
    logic [31:0] wc [N];
    logic [31:0] rc [N];
    logic [15:0] oc [N];
`endif

    debug_bus_ram u0 (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en[0]), .wr_rdy(wr_rdy[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_rdy(rd_rdy[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0])
`ifdef DEBUG_BUS_RAM_STATS_EN
        , .wr_cnt(wc[0]), .rd_cnt(rc[0]), .oor_cnt(oc[0])
`endif
    );

    debug_bus_ram #(.RD_LATENCY(8), .WR_LATENCY(8)) u1 (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en[1]), .wr_rdy(wr_rdy[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_rdy(rd_rdy[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1])
`ifdef DEBUG_BUS_RAM_STATS_EN
        , .wr_cnt(wc[1]), .rd_cnt(rc[1]), .oor_cnt(oc[1])
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_edge [N];
    int          rd_edge [N];
    logic [31:0] rd_old [N];
    logic [31:0] rd_new [N];
    int          wr_pulses [N];
    int          rd_pulses [N];
    int          last_rd_cyc [N];
    int          last_wr_cyc [N];
    int          last_t [N];
    logic [31:0] mem_m [int];

    function automatic int wlat(input int i);
        return (i == 0) ? 1 : 8;
    endfunction

    function automatic int rlat(input int i);
        return (i == 0) ? 2 : 8;
    endfunction

    function automatic logic [31:0] mem_get(input int i, input logic [31:0] a);
        int k = i * 4096 + int'(a);
        return mem_m.exists(k) ? mem_m[k] : 32'h0;
    endfunction

    function automatic logic [31:0] cur_rd(input int i);
        return (rd_edge[i] >= 0 && cyc >= rd_edge[i]) ? rd_new[i] : rd_old[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: each rdy must be high exactly on its predicted edge and rd_data must hold its predicted value
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d wr_rdy @%0d", i, cyc), 32'(wr_rdy[i]), 32'(cyc == wr_edge[i]));
            chk($sformatf("u%0d rd_rdy @%0d", i, cyc), 32'(rd_rdy[i]), 32'(cyc == rd_edge[i]));
            chk($sformatf("u%0d rd_data @%0d", i, cyc), rd_data[i], cur_rd(i));
            if (wr_rdy[i] === 1'b1) begin wr_pulses[i]++; last_wr_cyc[i] = cyc; end
            if (rd_rdy[i] === 1'b1) begin rd_pulses[i]++; last_rd_cyc[i] = cyc; end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic scramble(input int i);
        wr_addr[i] = $urandom;
        wr_data[i] = $urandom;
        rd_addr[i] = $urandom;
    endtask

    // One request on instance i, raised so the next edge samples it; abort_n>0 drops en after abort_n edges
    task automatic req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int abort_n, input int hold, input bit jitter);
        int t, r;
        t = cyc + 1;
        last_t[i] = t;
        if (wr) begin wr_addr[i] = a; wr_data[i] = d; wr_en[i] = 1'b1; end
        else begin rd_addr[i] = a; rd_en[i] = 1'b1; end
        if (a >= 32'd1024) begin
            repeat (hold + 1) step;
        end else if (abort_n > 0) begin
            repeat (abort_n) begin step; if (jitter) scramble(i); end
        end else begin
            r = t + (wr ? wlat(i) : rlat(i));
            if (wr) begin
                wr_edge[i] = r;
                mem_m[i * 4096 + int'(a)] = d;
            end else begin
                rd_old[i]  = cur_rd(i);
                rd_new[i]  = mem_get(i, a);
                rd_edge[i] = r;
            end
            while (cyc < r) begin step; if (jitter) scramble(i); end
            repeat (hold) step;
        end
        wr_en[i] = 1'b0;
        rd_en[i] = 1'b0;
        step;
    endtask

    // Write and read raised together: the write is served first, the held read after DONE releases
    task automatic both(input int i, input logic [31:0] a, input logic [31:0] d);
        int t, r1, r2;
        t = cyc + 1;
        wr_addr[i] = a; wr_data[i] = d; rd_addr[i] = a;
        wr_en[i] = 1'b1; rd_en[i] = 1'b1;
        r1 = t + wlat(i);
        r2 = r1 + 2 + rlat(i);
        wr_edge[i] = r1;
        mem_m[i * 4096 + int'(a)] = d;
        rd_old[i]  = cur_rd(i);
        rd_new[i]  = d;
        rd_edge[i] = r2;
        while (cyc < r1) step;
        wr_en[i] = 1'b0;
        while (cyc < r2) step;
        rd_en[i] = 1'b0;
        step;
    endtask

    function automatic logic [31:0] pool_addr();
        return $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(1008, 1023));
    endfunction

    initial begin
        int wp, rp, k, l;
        bit w;
        for (int i = 0; i < N; i++) begin
            wr_en[i] = 1'b0; rd_en[i] = 1'b0;
            wr_addr[i] = '0; wr_data[i] = '0; rd_addr[i] = '0;
            wr_edge[i] = -1; rd_edge[i] = -1;
            rd_old[i] = '0; rd_new[i] = '0;
            wr_pulses[i] = 0; rd_pulses[i] = 0;
            last_rd_cyc[i] = -1; last_wr_cyc[i] = -1; last_t[i] = 0;
        end
        repeat (3) step;
        rstn = 1'b1;
        step;
        chk("reset rd_data", rd_data[0], 32'h0);
        chk("reset wr_rdy", 32'(wr_rdy[0]), 32'h0);

        req(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        chk("wr latency", 32'(last_wr_cyc[0] - last_t[0]), 32'd1);
        req(0, 0, 32'h10, 0, 0, 0, 0);
        chk("rd latency", 32'(last_rd_cyc[0] - last_t[0]), 32'd2);
        chk("rd 0x10 held", rd_data[0], 32'hDEADBEEF);

        rp = rd_pulses[0];
        req(0, 0, 32'h400, 0, 0, 600, 0);
        chk("oor rd pulses", 32'(rd_pulses[0] - rp), 32'd0);
        chk("oor rd_data", rd_data[0], 32'hDEADBEEF);
        req(0, 1, 32'h3FF, 32'hCAFE0001, 0, 0, 0);
        req(0, 0, 32'h3FF, 0, 0, 0, 0);
        chk("rd 0x3ff", rd_data[0], 32'hCAFE0001);

        wp = wr_pulses[0]; rp = rd_pulses[0];
        both(0, 32'h5, 32'h1234);
        chk("both rd_data", rd_data[0], 32'h00001234);
        chk("both wr pulses", 32'(wr_pulses[0] - wp), 32'd1);
        chk("both rd pulses", 32'(rd_pulses[0] - rp), 32'd1);

        wp = wr_pulses[0];
        req(0, 1, 32'h6, 32'h600D, 0, 5, 0);
        chk("held wr pulses", 32'(wr_pulses[0] - wp), 32'd1);

        req(1, 1, 32'h20, 32'hAAAA5555, 0, 0, 0);
        req(1, 1, 32'h21, 32'h11112222, 0, 0, 0);
        req(1, 0, 32'h20, 0, 0, 0, 0);
        chk("u1 rd 0x20", rd_data[1], 32'hAAAA5555);
        rp = rd_pulses[1];
        req(1, 0, 32'h21, 0, 3, 0, 0);
        chk("u1 rd abort pulses", 32'(rd_pulses[1] - rp), 32'd0);
        chk("u1 rd abort data", rd_data[1], 32'hAAAA5555);
        wp = wr_pulses[1];
        req(1, 1, 32'h20, 32'hBBBBBBBB, 4, 0, 0);
        chk("u1 wr abort pulses", 32'(wr_pulses[1] - wp), 32'd0);
        req(1, 0, 32'h21, 0, 0, 0, 0);
        req(1, 0, 32'h20, 0, 0, 0, 0);
        chk("u1 old value after abort", rd_data[1], 32'hAAAA5555);

        for (int a = 0; a < 16; a++) req(0, 1, 32'(a), $urandom, 0, 0, 0);
        for (int a = 1008; a < 1024; a++) req(0, 1, 32'(a), $urandom, 0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            if (k < 4) req(0, 1, pool_addr(), $urandom, 0, $urandom_range(0, 3), 1);
            else if (k < 8) req(0, 0, pool_addr(), 0, 0, $urandom_range(0, 3), 1);
            else if (k == 8) req(0, w, $urandom_range(32'hFFFFFFFF, 1024), $urandom, 0, $urandom_range(0, 5), 0);
            else begin
                l = w ? wlat(0) : rlat(0);
                req(0, w, pool_addr(), $urandom, $urandom_range(1, l), 0, 1);
            end
        end

        rd_addr[1] = 32'h20;
        rd_en[1] = 1'b1;
        repeat (3) step;
        for (int i = 0; i < N; i++) begin
            wr_edge[i] = -1; rd_edge[i] = -1;
            rd_old[i] = '0; rd_new[i] = '0;
        end
        rstn = 1'b0;
        #1;
        chk("reset mid-read rd_rdy", 32'(rd_rdy[1]), 32'h0);
        chk("reset mid-read rd_data", rd_data[1], 32'h0);
        rd_en[1] = 1'b0;
        step;
        step;
        rstn = 1'b1;
        step;
        req(1, 0, 32'h20, 0, 0, 0, 0);
        chk("u1 ram kept over reset", rd_data[1], 32'hAAAA5555);
        req(0, 0, 32'h10, 0, 0, 0, 0);
        chk("u0 ram kept over reset", rd_data[0], 32'hDEADBEEF);
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
